// File: rtl/mux_sel_ctrl.sv
// mux_sel_ctrl: select generator for the 4:1 switch mux.
// Two raw pushbuttons are synchronized, debounced and edge-detected:
//   - btn_step advances sel by one while in MANUAL.
//   - btn_mode toggles between MANUAL and AUTO.
// In AUTO a prescaler advances sel once every SCAN_DIV cycles.
//
// Ports:
//   clk          system clock, all state on the rising edge
//   rst_n        asynchronous active-low reset
//   btn_step     raw step pushbutton, active-high, asynchronous
//   btn_mode     raw mode pushbutton, active-high, asynchronous
//   sel          registered select word (drives mux Sel)
//   sel_changed  one-cycle pulse in the first cycle sel holds a new value
//   auto_mode    1 while the FSM is in AUTO; this is the FSM state itself,
//                so it doubles as the state debug output
//
// Handshake note: there is no valid/ready traffic here. The button inputs
// are level inputs with no ready, and the outputs are plain registered
// levels/pulses with no back-pressure.
module mux_sel_ctrl #(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SCAN_DIV        = 25000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_step,
  input  logic             btn_mode,
  output logic [WIDTH-1:0] sel,
  output logic             sel_changed,
  output logic             auto_mode
);

  localparam int DB_W = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam int SC_W = ($clog2(SCAN_DIV) < 1) ? 1 : $clog2(SCAN_DIV);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCAN_DIV - 1);

  // Bit 0 = step button, bit 1 = mode button.
  logic [1:0] raw;
  logic [1:0] sync1_q;
  logic [1:0] sync2_q;
  logic [1:0] db_q;      // debounced level
  logic [1:0] db_dly_q;  // debounced level delayed one cycle
  logic [DB_W-1:0] db_cnt_q [2];

  assign raw = {btn_mode, btn_step};

  // Synchronizer + debounce for both buttons. The counter only runs while
  // the synchronized level disagrees with the accepted level, so any return
  // to the accepted level before the count completes discards the glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      db_q        <= '0;
      db_dly_q    <= '0;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      db_dly_q <= db_q;
      for (int b = 0; b < 2; b++) begin
        if (sync2_q[b] == db_q[b]) begin
          db_cnt_q[b] <= '0;
        end else if (db_cnt_q[b] == DB_LAST) begin
          db_q[b]     <= sync2_q[b];
          db_cnt_q[b] <= '0;
        end else begin
          db_cnt_q[b] <= db_cnt_q[b] + DB_W'(1);
        end
      end
    end
  end

  // Rising edges of the debounced levels only; releases do nothing.
  logic step_press;
  logic mode_press;
  assign step_press = db_q[0] & ~db_dly_q[0];
  assign mode_press = db_q[1] & ~db_dly_q[1];

  typedef enum logic {
    MANUAL = 1'b0,
    AUTO   = 1'b1
  } state_e;

  state_e          state_q;
  logic [WIDTH-1:0] sel_q;
  logic             sel_changed_q;
  logic [SC_W-1:0]  presc_q;
  logic             scan_tc;

  assign scan_tc = (presc_q == SC_LAST);

  // Mode press has priority: when it coincides with a step press or a scan
  // terminal count, only the state flips and sel is left alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= MANUAL;
      sel_q         <= '0;
      sel_changed_q <= 1'b0;
      presc_q       <= '0;
    end else begin
      sel_changed_q <= 1'b0;
      case (state_q)
        MANUAL: begin
          presc_q <= '0;
          if (mode_press) begin
            state_q <= AUTO;
          end else if (step_press) begin
            sel_q         <= sel_q + WIDTH'(1);
            sel_changed_q <= 1'b1;
          end
        end
        AUTO: begin
          if (mode_press) begin
            state_q <= MANUAL;
            presc_q <= '0;
          end else if (scan_tc) begin
            presc_q       <= '0;
            sel_q         <= sel_q + WIDTH'(1);
            sel_changed_q <= 1'b1;
          end else begin
            presc_q <= presc_q + SC_W'(1);
          end
        end
        default: begin
          state_q <= MANUAL;
          presc_q <= '0;
        end
      endcase
    end
  end

  assign sel         = sel_q;
  assign sel_changed = sel_changed_q;
  assign auto_mode   = (state_q == AUTO);

endmodule
